// File: rtl/mem_dma_if.sv
// rtl/mem_dma_if.sv - RAM port B bundle between mem_dma and the 16K x 8 dual-port RAM
interface mem_dma_if #(
  parameter int AW = 14,
  parameter int DW = 8
);
  logic [AW-1:0] ad;
  logic [DW-1:0] din;
  logic [DW-1:0] dout;
  logic          ce;
  logic          wre;
  logic          oce;

  modport master (output ad, din, ce, wre, oce, input dout);
  modport slave  (input ad, din, ce, wre, oce, output dout);
endinterface

// File: rtl/mem_dma.sv
// rtl/mem_dma.sv - byte-wide copy/fill engine driving RAM port B
module mem_dma #(
  parameter int AW = 14,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic          mode,
  input  logic [AW-1:0] src,
  input  logic [AW-1:0] dst,
  input  logic [AW:0]   len,
  input  logic [DW-1:0] fill_val,
  output logic          busy,
  output logic          done,
  mem_dma_if.master     ram
);

  typedef enum logic [2:0] {IDLE, RD, WR, FILL, FIN} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] cur_src, cur_dst;
  logic [AW:0]   remain;
  logic          step_down;
  logic [DW-1:0] fill_q;

  logic [AW-1:0] gap;
  logic [AW-1:0] last_ofs;
  logic          desc;
  logic          last;

  // Overlapping copy with dst ahead of src must run top-down to avoid clobbering unread bytes.
  assign gap      = dst - src;
  assign desc     = ~mode && (dst != src) && ({1'b0, gap} < len);
  assign last_ofs = len[AW-1:0] - 1'b1;
  assign last     = (remain == {{AW{1'b0}}, 1'b1});

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (len == '0)  state_nxt = FIN;
          else if (mode)  state_nxt = FILL;
          else            state_nxt = RD;
        end
      end
      RD:      state_nxt = abort ? IDLE : WR;
      WR:      state_nxt = abort ? IDLE : (last ? FIN : RD);
      FILL:    state_nxt = abort ? IDLE : (last ? FIN : FILL);
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      cur_src   <= '0;
      cur_dst   <= '0;
      remain    <= '0;
      step_down <= 1'b0;
      fill_q    <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            fill_q    <= fill_val;
            remain    <= len;
            step_down <= desc;
            cur_src   <= desc ? src + last_ofs : src;
            cur_dst   <= desc ? dst + last_ofs : dst;
          end
        end
        RD: begin
          cur_src <= step_down ? cur_src - 1'b1 : cur_src + 1'b1;
        end
        WR, FILL: begin
          remain  <= remain - 1'b1;
          cur_dst <= step_down ? cur_dst - 1'b1 : cur_dst + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy    = (state == RD) || (state == WR) || (state == FILL);
  assign done    = (state == FIN);
  assign ram.ce  = busy;
  assign ram.wre = (state == WR) || (state == FILL);
  assign ram.ad  = (state == RD) ? cur_src : cur_dst;
  assign ram.oce = 1'b1;
  // dout is the RAM's own output register, so forwarding it in WR adds no input-to-output path.
  assign ram.din = (state == WR)   ? ram.dout :
                   (state == FILL) ? fill_q   : '0;

endmodule
